// File: rtl/gpio_pulse_meas_if.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_pulse_meas_if
//  Description : Signal bundle for the GPIO pulse-width measurement unit.
//                The master modport drives the pad inputs and control fields.
//                The slave modport (the measurement unit) returns status,
//                strobes and the per-channel results.
//  Signals     : pulse_i   - raw asynchronous pad inputs, one per channel
//                start_i   - one-cycle arm strobe per channel
//                level_i   - polarity to measure (1 = high pulse)
//                presc_i   - tick period minus one, shared by all channels
//                timeout_i - timeout in ticks (0 = none), sampled at arm
//                busy_o    - channel armed or measuring
//                done_o    - one-cycle strobe, measurement valid
//                timeout_o - one-cycle strobe, channel timed out
//                width_o   - last result, channel k at [k*CNT_W +: CNT_W]
//  Revision    : 1.0 - initial release
// ============================================================================
interface gpio_pulse_meas_if #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 16
);
    logic [N_CH-1:0]       pulse_i;
    logic [N_CH-1:0]       start_i;
    logic [N_CH-1:0]       level_i;
    logic [PRESC_W-1:0]    presc_i;
    logic [CNT_W-1:0]      timeout_i;
    logic [N_CH-1:0]       busy_o;
    logic [N_CH-1:0]       done_o;
    logic [N_CH-1:0]       timeout_o;
    logic [N_CH*CNT_W-1:0] width_o;

    modport master (
        output pulse_i, start_i, level_i, presc_i, timeout_i,
        input  busy_o, done_o, timeout_o, width_o
    );

    modport slave (
        input  pulse_i, start_i, level_i, presc_i, timeout_i,
        output busy_o, done_o, timeout_o, width_o
    );
endinterface
`default_nettype wire

// File: rtl/gpio_pulse_meas.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_pulse_meas
//  Description : Multi-channel hardware pulse-width measurement. Each channel
//                is armed independently, waits for any pulse already in
//                progress to end, then measures the next pulse of the chosen
//                polarity in prescaled ticks, with an optional timeout.
//  Ports       : clk   - system clock
//                rst_n - asynchronous active-low reset
//                bus   - gpio_pulse_meas_if.slave (inputs, strobes, results)
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_pulse_meas #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 32,
    parameter int PRESC_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    gpio_pulse_meas_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_IDLE  = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_MEASURE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;

    // ------------------------------------------------------------------
    // Input synchronisers: all edge decisions use the last stage only.
    // ------------------------------------------------------------------
    logic [N_CH-1:0] r_sync [SYNC_STAGES];
    logic [N_CH-1:0] w_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= bus.pulse_i;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Shared tick prescaler. Compare with >= so that lowering presc_i
    // below the running count takes effect on the next cycle instead of
    // waiting for a full counter wrap.
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] r_presc_cnt;
    logic               w_tick;

    assign w_tick = (r_presc_cnt >= bus.presc_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_presc_cnt <= '0;
        else if (w_tick) r_presc_cnt <= '0;
        else             r_presc_cnt <= r_presc_cnt + 1'b1;
    end

    // ------------------------------------------------------------------
    // Per-channel measurement FSMs
    // ------------------------------------------------------------------
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        state_t           r_state,   w_state_nxt;
        logic             r_level,   w_level_nxt;
        logic [CNT_W-1:0] r_tmo,     w_tmo_nxt;
        logic [CNT_W-1:0] r_elapsed, w_elapsed_nxt;
        logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
        logic [CNT_W-1:0] r_width,   w_width_nxt;
        logic             r_done,    w_done_nxt;
        logic             r_tout,    w_tout_nxt;
        logic [CNT_W-1:0] w_elapsed_inc;
        logic [CNT_W-1:0] w_tick_ext;
        logic             w_tmo_hit;
        logic             w_at_level;

        assign w_tick_ext    = {{(CNT_W-1){1'b0}}, w_tick};
        assign w_elapsed_inc = r_elapsed + w_tick_ext;
        assign w_tmo_hit     = (r_tmo != c_CNT_ZERO) && (w_elapsed_inc == r_tmo);
        assign w_at_level    = (w_s[k] == r_level);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state   <= ST_IDLE;
                r_level   <= 1'b0;
                r_tmo     <= '0;
                r_elapsed <= '0;
                r_cnt     <= '0;
                r_width   <= '0;
                r_done    <= 1'b0;
                r_tout    <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_level   <= w_level_nxt;
                r_tmo     <= w_tmo_nxt;
                r_elapsed <= w_elapsed_nxt;
                r_cnt     <= w_cnt_nxt;
                r_width   <= w_width_nxt;
                r_done    <= w_done_nxt;
                r_tout    <= w_tout_nxt;
            end
        end

        always_comb begin
            w_state_nxt   = r_state;
            w_level_nxt   = r_level;
            w_tmo_nxt     = r_tmo;
            w_elapsed_nxt = r_elapsed;
            w_cnt_nxt     = r_cnt;
            w_width_nxt   = r_width;
            w_done_nxt    = 1'b0;
            w_tout_nxt    = 1'b0;

            if (bus.start_i[k]) begin
                // Arm (or silently restart); suppresses any strobe this cycle.
                w_level_nxt   = bus.level_i[k];
                w_tmo_nxt     = bus.timeout_i;
                w_elapsed_nxt = '0;
                w_state_nxt   = ST_WAIT_IDLE;
            end else begin
                if (r_state != ST_IDLE) w_elapsed_nxt = w_elapsed_inc;
                case (r_state)
                    ST_WAIT_IDLE: begin
                        if (!w_at_level) w_state_nxt = ST_WAIT_START;
                    end
                    ST_WAIT_START: begin
                        if (w_at_level) begin
                            w_state_nxt = ST_MEASURE;
                            w_cnt_nxt   = w_tick_ext;
                        end
                    end
                    ST_MEASURE: begin
                        if (w_at_level) begin
                            if (r_cnt != c_CNT_MAX) w_cnt_nxt = r_cnt + w_tick_ext;
                        end else begin
                            w_width_nxt = r_cnt;
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                    default: ;
                endcase
                // End of pulse has priority over a coincident timeout.
                if (r_state != ST_IDLE && !w_done_nxt && w_tmo_hit) begin
                    w_width_nxt = '0;
                    w_tout_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
        end

        assign bus.busy_o[k]                   = (r_state != ST_IDLE);
        assign bus.done_o[k]                   = r_done;
        assign bus.timeout_o[k]                = r_tout;
        assign bus.width_o[k*CNT_W +: CNT_W]   = r_width;
    end

endmodule
`default_nettype wire

// File: tb/tb_gpio_pulse_meas.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_pulse_meas
//  Description : Directed self-checking bench for gpio_pulse_meas.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_pulse_meas;
    localparam int N_CH    = 4;
    localparam int CNT_W   = 32;
    localparam int PRESC_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #20 clk = ~clk;

    gpio_pulse_meas_if #(.N_CH(N_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) ifc ();

    gpio_pulse_meas #(
        .N_CH(N_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W), .SYNC_STAGES(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int done_cnt [N_CH];
    int tmo_cnt  [N_CH];
    int done_cyc [N_CH];

    function automatic logic [CNT_W-1:0] width_of(input int k);
        return ifc.width_o[k*CNT_W +: CNT_W];
    endfunction

    // Advance n cycles, sampling strobes on each falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < N_CH; k++) begin
                if (ifc.done_o[k])    begin done_cnt[k]++; done_cyc[k] = cyc; end
                if (ifc.timeout_o[k]) tmo_cnt[k]++;
            end
        end
    endtask

    task automatic clr_counts();
        for (int k = 0; k < N_CH; k++) begin
            done_cnt[k] = 0; tmo_cnt[k] = 0; done_cyc[k] = 0;
        end
    endtask

    task automatic arm(input logic [N_CH-1:0] mask, input logic [N_CH-1:0] lvl,
                       input logic [CNT_W-1:0] tmo);
        ifc.level_i   = lvl;
        ifc.timeout_i = tmo;
        ifc.start_i   = mask;
        step(1);
        ifc.start_i   = '0;
    endtask

    task automatic test_reset();
        n_checks++; if (ifc.busy_o !== 4'h0) begin n_errors++; $display("FAIL reset_busy: got %h expected 0", ifc.busy_o); end
        n_checks++; if (ifc.done_o !== 4'h0) begin n_errors++; $display("FAIL reset_done: got %h expected 0", ifc.done_o); end
        n_checks++; if (ifc.timeout_o !== 4'h0) begin n_errors++; $display("FAIL reset_timeout: got %h expected 0", ifc.timeout_o); end
        n_checks++; if (ifc.width_o !== '0) begin n_errors++; $display("FAIL reset_width: got %h expected 0", ifc.width_o); end
    endtask

    task automatic test_basic();
        clr_counts();
        ifc.presc_i = '0;
        arm(4'b0001, 4'b0001, 0);
        n_checks++; if (ifc.busy_o[0] !== 1'b1) begin n_errors++; $display("FAIL basic_busy: got %b expected 1", ifc.busy_o[0]); end
        step(1250);
        ifc.pulse_i[0] = 1'b1; step(12500);
        ifc.pulse_i[0] = 1'b0; step(10);
        n_checks++; if (done_cnt[0] != 1) begin n_errors++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt[0]); end
        n_checks++; if (width_of(0) !== 32'd12500) begin n_errors++; $display("FAIL basic_width: got %0d expected 12500", width_of(0)); end
        n_checks++; if (tmo_cnt[0] != 0) begin n_errors++; $display("FAIL basic_timeout: got %0d expected 0", tmo_cnt[0]); end
        n_checks++; if (ifc.busy_o[0] !== 1'b0) begin n_errors++; $display("FAIL basic_idle: got %b expected 0", ifc.busy_o[0]); end
    endtask

    task automatic test_prescale();
        clr_counts();
        ifc.presc_i = 16'd24;
        ifc.pulse_i[1] = 1'b1; step(5);
        arm(4'b0010, 4'b0000, 0);
        step(100);
        ifc.pulse_i[1] = 1'b0; step(25000);
        ifc.pulse_i[1] = 1'b1; step(60);
        n_checks++; if (done_cnt[1] != 1) begin n_errors++; $display("FAIL presc_done_count: got %0d expected 1", done_cnt[1]); end
        n_checks++; if (width_of(1) < 32'd999 || width_of(1) > 32'd1001) begin n_errors++; $display("FAIL presc_width: got %0d expected 999..1001", width_of(1)); end
        ifc.presc_i = '0;
    endtask

    task automatic test_prearmed();
        clr_counts();
        ifc.pulse_i[2] = 1'b1; step(5);
        arm(4'b0100, 4'b0100, 0);
        step(200);
        n_checks++; if (done_cnt[2] != 0 || ifc.busy_o[2] !== 1'b1) begin n_errors++; $display("FAIL prearm_wait: got done=%0d busy=%b expected 0/1", done_cnt[2], ifc.busy_o[2]); end
        ifc.pulse_i[2] = 1'b0; step(50);
        ifc.pulse_i[2] = 1'b1; step(300);
        ifc.pulse_i[2] = 1'b0; step(10);
        n_checks++; if (done_cnt[2] != 1) begin n_errors++; $display("FAIL prearm_done_count: got %0d expected 1", done_cnt[2]); end
        n_checks++; if (width_of(2) !== 32'd300) begin n_errors++; $display("FAIL prearm_width: got %0d expected 300", width_of(2)); end
    endtask

    task automatic test_timeout();
        int hit;
        clr_counts();
        arm(4'b1000, 4'b1000, 0);
        step(5);
        ifc.pulse_i[3] = 1'b1; step(20);
        ifc.pulse_i[3] = 1'b0; step(10);
        n_checks++; if (width_of(3) !== 32'd20) begin n_errors++; $display("FAIL tmo_pre_width: got %0d expected 20", width_of(3)); end
        clr_counts();
        hit = -1;
        arm(4'b1000, 4'b1000, 32'd1000);
        for (int i = 1; i <= 1100; i++) begin
            step(1);
            if (hit < 0 && ifc.timeout_o[3]) hit = i;
        end
        n_checks++; if (hit < 999 || hit > 1001) begin n_errors++; $display("FAIL tmo_latency: got %0d expected 999..1001", hit); end
        n_checks++; if (width_of(3) !== 32'd0) begin n_errors++; $display("FAIL tmo_width: got %0d expected 0", width_of(3)); end
        n_checks++; if (ifc.busy_o[3] !== 1'b0) begin n_errors++; $display("FAIL tmo_busy: got %b expected 0", ifc.busy_o[3]); end
        n_checks++; if (tmo_cnt[3] != 1 || done_cnt[3] != 0) begin n_errors++; $display("FAIL tmo_strobes: got tmo=%0d done=%0d expected 1/0", tmo_cnt[3], done_cnt[3]); end
    endtask

    task automatic test_all_channels();
        clr_counts();
        ifc.pulse_i = 4'h0; step(5);
        arm(4'hF, 4'hF, 0);
        step(5);
        ifc.pulse_i = 4'hF;
        step(100); ifc.pulse_i[0] = 1'b0;
        step(100); ifc.pulse_i[1] = 1'b0;
        step(100); ifc.pulse_i[2] = 1'b0;
        step(100); ifc.pulse_i[3] = 1'b0;
        step(10);
        for (int k = 0; k < N_CH; k++) begin
            n_checks++;
            if (width_of(k) !== 32'((k + 1) * 100)) begin n_errors++; $display("FAIL all_width ch%0d: got %0d expected %0d", k, width_of(k), (k + 1) * 100); end
        end
        n_checks++; if (done_cnt[0] != 1 || done_cnt[1] != 1 || done_cnt[2] != 1 || done_cnt[3] != 1) begin n_errors++; $display("FAIL all_done_count: got %0d %0d %0d %0d expected 1 1 1 1", done_cnt[0], done_cnt[1], done_cnt[2], done_cnt[3]); end
        n_checks++; if (!(done_cyc[0] < done_cyc[1] && done_cyc[1] < done_cyc[2] && done_cyc[2] < done_cyc[3])) begin n_errors++; $display("FAIL all_order: got %0d %0d %0d %0d expected increasing", done_cyc[0], done_cyc[1], done_cyc[2], done_cyc[3]); end
        n_checks++; if (tmo_cnt[0] + tmo_cnt[1] + tmo_cnt[2] + tmo_cnt[3] != 0) begin n_errors++; $display("FAIL all_timeout: got %0d expected 0", tmo_cnt[0] + tmo_cnt[1] + tmo_cnt[2] + tmo_cnt[3]); end
    endtask

    task automatic test_rearm();
        clr_counts();
        arm(4'b0001, 4'b0001, 0);
        step(3);
        ifc.pulse_i[0] = 1'b1; step(30);
        arm(4'b0001, 4'b0001, 0);
        step(20);
        ifc.pulse_i[0] = 1'b0; step(20);
        n_checks++; if (done_cnt[0] != 0 || tmo_cnt[0] != 0) begin n_errors++; $display("FAIL rearm_strobe: got done=%0d tmo=%0d expected 0/0", done_cnt[0], tmo_cnt[0]); end
        n_checks++; if (width_of(0) !== 32'd100) begin n_errors++; $display("FAIL rearm_width_kept: got %0d expected 100", width_of(0)); end
        n_checks++; if (ifc.busy_o[0] !== 1'b1) begin n_errors++; $display("FAIL rearm_busy: got %b expected 1", ifc.busy_o[0]); end
        ifc.pulse_i[0] = 1'b1; step(40);
        ifc.pulse_i[0] = 1'b0; step(10);
        n_checks++; if (width_of(0) !== 32'd40 || done_cnt[0] != 1) begin n_errors++; $display("FAIL rearm_width: got %0d/%0d expected 40/1", width_of(0), done_cnt[0]); end
    endtask

    // Start lands on the same edge where the end of pulse is decided.
    task automatic test_back_to_back();
        clr_counts();
        arm(4'b0001, 4'b0001, 0);
        step(3);
        ifc.pulse_i[0] = 1'b1; step(25);
        ifc.pulse_i[0] = 1'b0; step(2);
        arm(4'b0001, 4'b0001, 0);
        step(10);
        n_checks++; if (done_cnt[0] != 0 || ifc.busy_o[0] !== 1'b1) begin n_errors++; $display("FAIL b2b_start_wins: got done=%0d busy=%b expected 0/1", done_cnt[0], ifc.busy_o[0]); end
        n_checks++; if (width_of(0) !== 32'd40) begin n_errors++; $display("FAIL b2b_width_kept: got %0d expected 40", width_of(0)); end
        ifc.pulse_i[0] = 1'b1; step(15);
        ifc.pulse_i[0] = 1'b0; step(10);
        n_checks++; if (width_of(0) !== 32'd15 || done_cnt[0] != 1) begin n_errors++; $display("FAIL b2b_width: got %0d/%0d expected 15/1", width_of(0), done_cnt[0]); end
    endtask

    task automatic test_reset_mid();
        clr_counts();
        arm(4'b0010, 4'b0010, 0);
        step(3);
        ifc.pulse_i[1] = 1'b1; step(50);
        rst_n = 1'b0; step(1);
        n_checks++; if (ifc.busy_o !== 4'h0 || ifc.done_o !== 4'h0 || ifc.timeout_o !== 4'h0) begin n_errors++; $display("FAIL rstmid_flags: got busy=%h done=%h tmo=%h expected 0", ifc.busy_o, ifc.done_o, ifc.timeout_o); end
        n_checks++; if (ifc.width_o !== '0) begin n_errors++; $display("FAIL rstmid_width: got %h expected 0", ifc.width_o); end
        n_checks++; if (done_cnt[1] != 0) begin n_errors++; $display("FAIL rstmid_strobe: got %0d expected 0", done_cnt[1]); end
        rst_n = 1'b1;
        ifc.pulse_i[1] = 1'b0; step(5);
        clr_counts();
        arm(4'b0010, 4'b0010, 0);
        step(3);
        ifc.pulse_i[1] = 1'b1; step(50);
        ifc.pulse_i[1] = 1'b0; step(10);
        n_checks++; if (width_of(1) !== 32'd50 || done_cnt[1] != 1) begin n_errors++; $display("FAIL rstmid_width_after: got %0d/%0d expected 50/1", width_of(1), done_cnt[1]); end
    endtask

    initial begin
        rst_n         = 1'b0;
        ifc.pulse_i   = '0;
        ifc.start_i   = '0;
        ifc.level_i   = '0;
        ifc.presc_i   = '0;
        ifc.timeout_i = '0;
        clr_counts();
        step(3);
        test_reset();
        rst_n = 1'b1;
        step(2);
        test_basic();
        test_prescale();
        test_prearmed();
        test_timeout();
        test_all_channels();
        test_rearm();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
